// File: rtl/kbd_event_decoder.sv
// ---------------------------------------------------------------------------
// kbd_event_decoder
//
// Turns the PS/2 scan-code byte stream into key events. An E0 prefix marks
// the key as extended and an F0 prefix marks it as a release. The next
// ordinary byte completes an event {code, ext, break}. Events go into a
// small FIFO that a consumer drains through a valid/ready handshake.
//
// Optional feature (macro KBD_TYPEMATIC_FILTER_EN): this adds a typematic
// filter. Make events that repeat the most recent make are suppressed until
// the matching release arrives. With the macro undefined, every make event
// is queued, including keyboard auto-repeats.
//
// Parameters
//   DEPTH  event FIFO depth in entries (power of two, >= 2)
//   CNT_W  width of the release-event counter
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   scan-code byte present this cycle
//   in_data    scan-code byte
//   in_ready   always 1; the decoder never stalls its input
//   evt_valid  FIFO non-empty, head event valid
//   evt_ready  consumer pops the head when evt_valid is also high
//   evt_code   head event key code
//   evt_ext    head event was E0-prefixed
//   evt_break  head event is a release
//   key_cnt    number of release events decoded (wraps)
//   overflow   sticky: an event was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module kbd_event_decoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_break,
   output logic [CNT_W-1:0] key_cnt,
   output logic             overflow
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t          state_reg;
   logic [9:0]      mem_reg [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     occ_reg;
   logic [CNT_W-1:0] key_cnt_reg;
   logic            overflow_reg;

   logic is_e0, is_f0, is_err;
   logic gen_evt, gen_ext, gen_brk;
   logic suppress;
   logic push_req, push, pop, full, drop;

   assign in_ready = 1'b1;

   assign is_e0  = (in_data == 8'hE0);
   assign is_f0  = (in_data == 8'hF0);
   assign is_err = (in_data == 8'h00) || (in_data == 8'hFF);

   // A completed event. Gating it with rst keeps any byte that arrives
   // during a reset cycle out of the FIFO, the counter and the filter.
   assign gen_evt = in_valid && !rst && !is_e0 && !is_f0 && !is_err;
   assign gen_ext = (state_reg == EXT) || (state_reg == EXT_BRK);
   assign gen_brk = (state_reg == BRK) || (state_reg == EXT_BRK);

   // Prefix decoder. Prefix bytes accumulate; any other byte ends the
   // sequence, whether it is an error byte or an event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else if (in_valid) begin
         if (is_e0) begin
            case (state_reg)
               IDLE:    state_reg <= EXT;
               BRK:     state_reg <= EXT_BRK;
               default: state_reg <= state_reg;
            endcase
         end else if (is_f0) begin
            case (state_reg)
               IDLE:    state_reg <= BRK;
               EXT:     state_reg <= EXT_BRK;
               default: state_reg <= state_reg;
            endcase
         end else begin
            state_reg <= IDLE;
         end
      end
   end

`ifdef KBD_TYPEMATIC_FILTER_EN
   // This register remembers the last make that was queued. Auto-repeats of
   // the same key match it and are swallowed. The release of that key
   // clears it, so the next press of the key goes through.
   logic       tm_valid_reg;
   logic       tm_ext_reg;
   logic [7:0] tm_code_reg;
   logic       tm_match;

   assign tm_match = tm_valid_reg && (tm_ext_reg == gen_ext) && (tm_code_reg == in_data);
   assign suppress = gen_evt && !gen_brk && tm_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         tm_valid_reg <= 1'b0;
         tm_ext_reg   <= 1'b0;
         tm_code_reg  <= 8'h00;
      end else if (gen_evt) begin
         if (!gen_brk) begin
            if (!tm_match) begin
               tm_valid_reg <= 1'b1;
               tm_ext_reg   <= gen_ext;
               tm_code_reg  <= in_data;
            end
         end else if (tm_match) begin
            tm_valid_reg <= 1'b0;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   // FIFO control. When the FIFO is full, a pop on the same cycle frees the
   // slot that the push needs. When it is empty there is nothing to pop, so
   // evt_valid low already blocks a pop.
   assign full     = (occ_reg == FULL_OCC);
   assign pop      = (occ_reg != '0) && evt_ready;
   assign push_req = gen_evt && !suppress;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= {gen_ext, gen_brk, in_data};
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (push && !pop) begin
            occ_reg <= occ_reg + (AW+1)'(1);
         end else if (pop && !push) begin
            occ_reg <= occ_reg - (AW+1)'(1);
         end
      end
   end

   // The counter counts every decoded release, including releases that are
   // dropped on overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_cnt_reg  <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (gen_evt && gen_brk) begin
            key_cnt_reg <= key_cnt_reg + CNT_W'(1);
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign evt_valid = (occ_reg != '0);
   assign {evt_ext, evt_break, evt_code} = mem_reg[rd_ptr_reg];
   assign key_cnt   = key_cnt_reg;
   assign overflow  = overflow_reg;

endmodule
